// File: rtl/pid_pkg.sv
// pid_pkg: FSM state encoding, default widths and the clamp helper for pid_scheduler.
package pid_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MUL_P, MUL_I, MUL_D, ACC, DONE} state_t;

    localparam int W_DEF  = 15;
    localparam int KW_DEF = 8;

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

endpackage

// File: rtl/pid_rr_arb.sv
// pid_rr_arb: combinational round-robin arbiter, grants the first requester at or after ptr_i.
module pid_rr_arb #(
    parameter int N_CH = 4,
    localparam int CW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CW-1:0]   ptr_i,
    output logic [CW-1:0]   idx_o,
    output logic            vld_o
);

    // Scan offsets from far to near so the nearest requester wins.
    always_comb begin
        idx_o = '0;
        vld_o = |req_i;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N_CH]) idx_o = CW'((int'(ptr_i) + i) % N_CH);
        end
    end

endmodule

// File: rtl/pid_scheduler.sv
// pid_scheduler: time-multiplexed incremental PID for N_CH loops over one multiplier.
// Define PID_SAT_EN to clamp du and u(k) instead of wrapping them two's-complement.
module pid_scheduler
    import pid_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = W_DEF,
    parameter int KW    = KW_DEF,
    parameter int SHIFT = 0,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        req,
    input  logic [N_CH*W-1:0]      err,
    input  logic signed [KW-1:0]   kp,
    input  logic signed [KW-1:0]   ki,
    input  logic signed [KW-1:0]   kd,
    output logic [N_CH-1:0]        ack,
    output logic                   uk_valid,
    output logic [CW-1:0]          uk_ch,
    output logic signed [W-1:0]    uk,
    output logic                   busy
);

    localparam int AW = W + KW + 4;

    state_t                state_q, state_d;
    logic [CW-1:0]         ptr_q, g_q, arb_idx;
    logic                  arb_vld;
    logic signed [W-1:0]   e1_q [N_CH];
    logic signed [W-1:0]   e2_q [N_CH];
    logic signed [W-1:0]   u_q  [N_CH];
    logic signed [W-1:0]   e_q, e_in, du, u_new;
    logic signed [W+1:0]   dp_q, di_q, dd_q, e_x, e1_x, e2_x;
    logic signed [KW-1:0]  kp_q, ki_q, kd_q;
    logic signed [AW-1:0]  acc_q, mul_a, mul_b, prod, sh;
    logic signed [W:0]     sum;
    logic [N_CH-1:0]       ack_q;
    logic                  uk_valid_q, busy_q;
    logic [CW-1:0]         uk_ch_q;
    logic signed [W-1:0]   uk_q;

    assign ack      = ack_q;
    assign uk_valid = uk_valid_q;
    assign uk_ch    = uk_ch_q;
    assign uk       = uk_q;
    assign busy     = busy_q;

    pid_rr_arb #(.N_CH(N_CH)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arb_vld ? LOAD : IDLE;
            LOAD:    state_d = MUL_P;
            MUL_P:   state_d = MUL_I;
            MUL_I:   state_d = MUL_D;
            MUL_D:   state_d = ACC;
            ACC:     state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        e_in  = $signed(err[g_q*W +: W]);
        e_x   = (W+2)'(e_in);
        e1_x  = (W+2)'(e1_q[g_q]);
        e2_x  = (W+2)'(e2_q[g_q]);
        mul_a = state_q == MUL_P ? AW'(dp_q) : (state_q == MUL_I ? AW'(di_q) : AW'(dd_q));
        mul_b = state_q == MUL_P ? AW'(kp_q) : (state_q == MUL_I ? AW'(ki_q) : AW'(kd_q));
        prod  = mul_a * mul_b;
        sh    = acc_q >>> SHIFT;
`ifdef PID_SAT_EN
        du    = W'(sat(64'(sh), W));
        sum   = (W+1)'(u_q[g_q]) + (W+1)'(du);
        u_new = W'(sat(64'(sum), W));
`else
        du    = W'(sh);
        sum   = (W+1)'(u_q[g_q]) + (W+1)'(du);
        u_new = W'(sum);
`endif
    end

    // Result outputs are loaded in ACC so they are visible exactly during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            g_q        <= '0;
            e_q        <= '0;
            dp_q       <= '0;
            di_q       <= '0;
            dd_q       <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            acc_q      <= '0;
            ack_q      <= '0;
            uk_valid_q <= 1'b0;
            uk_ch_q    <= '0;
            uk_q       <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                e1_q[i] <= '0;
                e2_q[i] <= '0;
                u_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            busy_q     <= state_d != IDLE;
            ack_q      <= '0;
            uk_valid_q <= 1'b0;
            uk_ch_q    <= '0;
            uk_q       <= '0;
            if (state_q == IDLE) g_q <= arb_idx;
            if (state_q == LOAD) begin
                e_q  <= e_in;
                dp_q <= e_x - e1_x;
                di_q <= e_x;
                dd_q <= e_x - (e1_x <<< 1) + e2_x;
                kp_q <= kp;
                ki_q <= ki;
                kd_q <= kd;
            end
            if (state_q == MUL_P) acc_q <= prod;
            if (state_q == MUL_I || state_q == MUL_D) acc_q <= acc_q + prod;
            if (state_q == ACC) begin
                u_q[g_q]   <= u_new;
                e2_q[g_q]  <= e1_q[g_q];
                e1_q[g_q]  <= e_q;
                ptr_q      <= g_q == CW'(N_CH - 1) ? '0 : g_q + CW'(1);
                ack_q      <= N_CH'(1) << g_q;
                uk_valid_q <= 1'b1;
                uk_ch_q    <= g_q;
                uk_q       <= u_new;
            end
        end
    end

endmodule

// File: tb/tb_pid_scheduler.sv
// tb_pid_scheduler: scoreboard bench with an arithmetic PID reference model.
module tb_pid_scheduler;

    localparam int N  = 4;
    localparam int W  = 15;
    localparam int KW = 8;
    localparam longint UMAX = 16383;
    localparam longint UMIN = -16384;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req = '0;
    logic [N*W-1:0]       err;
    logic signed [W-1:0]  errv [N];
    logic signed [KW-1:0] kp = '0, ki = '0, kd = '0;
    logic [N-1:0]         ack;
    logic                 uk_valid;
    logic [1:0]           uk_ch;
    logic signed [W-1:0]  uk;
    logic                 busy;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    longint m_e1 [N];
    longint m_e2 [N];
    longint m_u  [N];
    int m_ptr = 0;

    typedef struct {int ch; longint uk; int cyc;} exp_t;
    exp_t sbq[$];

    pid_scheduler #(.N_CH(N), .W(W), .KW(KW), .SHIFT(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .err      (err),
        .kp       (kp),
        .ki       (ki),
        .kd       (kd),
        .ack      (ack),
        .uk_valid (uk_valid),
        .uk_ch    (uk_ch),
        .uk       (uk),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb for (int i = 0; i < N; i++) err[i*W +: W] = errv[i];

    function automatic void chk(string name, longint act, longint exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    function automatic longint lim(longint x);
`ifdef PID_SAT_EN
        return x > UMAX ? UMAX : (x < UMIN ? UMIN : x);
`else
        longint y;
        y = (x - UMIN) % 32768;
        if (y < 0) y += 32768;
        return y + UMIN;
`endif
    endfunction

    // Incremental PID law on plain integers: u += kp*dP + ki*e + kd*dD.
    function automatic longint model_serve(int g);
        longint e, s;
        e = errv[g];
        s = kp * (e - m_e1[g]) + ki * e + kd * (e - 2 * m_e1[g] + m_e2[g]);
        m_u[g]  = lim(m_u[g] + lim(s));
        m_e2[g] = m_e1[g];
        m_e1[g] = e;
        m_ptr   = (g + 1) % N;
        return m_u[g];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_e1[i] = 0;
            m_e2[i] = 0;
            m_u[i]  = 0;
        end
        m_ptr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        model_clear();
    endtask

    // Predict the whole grant sequence, push expectations, then drive and retire requests.
    task automatic batch(input logic [N-1:0] m0, input logic [N-1:0] late,
                         input logic [N-1:0] keep, input int n, input bit scramble);
        logic [N-1:0] pend;
        int c0, g, first, cnt, nserv;
        exp_t x;
        @(negedge clk);
        c0 = cyc;
        pend = m0;
        nserv = 0;
        first = -1;
        while (nserv < n && pend != '0) begin
            g = -1;
            for (int i = N - 1; i >= 0; i--) if (pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            if (first < 0) first = g;
            x.ch  = g;
            x.uk  = model_serve(g);
            x.cyc = c0 + 6 + 7 * nserv;
            sbq.push_back(x);
            if (!keep[g]) pend[g] = 1'b0;
            if (nserv == 0) pend = pend | late;
            nserv++;
        end
        req = m0;
        cnt = 0;
        for (int t = 0; t < 7 * n + 20 && cnt < nserv; t++) begin
            @(negedge clk);
            if (cyc == c0 + 2) req = req | late;
            if (scramble && cyc == c0 + 3) errv[first] = W'($urandom);
            if (|ack) begin
                cnt++;
                req = req & ~(ack & ~keep);
            end
        end
        req = '0;
        chk("acks_in_batch", cnt, nserv);
        if (cnt < nserv) sbq.delete();
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (uk_valid) begin
                if (sbq.size() == 0) chk("unexpected_uk_valid", uk_valid, 0);
                else begin
                    x = sbq.pop_front();
                    chk("uk_ch", uk_ch, x.ch);
                    chk("uk", uk, x.uk);
                    chk("ack_onehot", ack, 1 << x.ch);
                    chk("done_cycle", cyc, x.cyc);
                end
            end else begin
                chk("idle_ack", ack, 0);
                chk("idle_uk", uk, 0);
                chk("idle_uk_ch", uk_ch, 0);
            end
        end
    end

    initial begin
        int c0;
        logic [N-1:0] m0, late, keep;
        for (int i = 0; i < N; i++) errv[i] = '0;
        do_reset();
        kp = 8'sd2; ki = 8'sd1; kd = 8'sd0; errv[0] = 15'sd10;
        batch(4'b0001, '0, '0, 1, 1'b0);
        kd = 8'sd1;
        batch(4'b0001, '0, '0, 1, 1'b0);

        do_reset();
        kp = 8'sd3; ki = -8'sd2; kd = 8'sd1;
        for (int i = 0; i < N; i++) errv[i] = W'($urandom_range(0, 200)) - 15'sd100;
        batch(4'b1111, '0, 4'b1111, 5, 1'b0);

        do_reset();
        kp = 8'sd0; ki = 8'sd1; kd = 8'sd0; errv[1] = 15'sd16380;
        batch(4'b0010, '0, '0, 1, 1'b0);
        errv[1] = 15'sd30;
        batch(4'b0010, '0, '0, 1, 1'b0);

        do_reset();
        kp = 8'sd3; ki = 8'sd2; kd = 8'sd1; errv[2] = 15'sd100;
        @(negedge clk);
        c0 = cyc;
        req = 4'b0100;
        while (cyc < c0 + 3) @(negedge clk);
        chk("busy_in_mul_i", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("busy_after_abort", busy, 0);
        chk("ack_after_abort", ack, 0);
        rst = 1'b0;
        req = '0;
        model_clear();
        errv[2] = 15'sd50;
        batch(4'b0100, '0, '0, 1, 1'b0);

        kp = 8'sd5; ki = -8'sd3; kd = 8'sd2;
        errv[0] = 15'sd1234; errv[3] = -15'sd777;
        batch(4'b0001, 4'b1000, '0, 2, 1'b1);

        repeat (30) begin
            kp = KW'($urandom);
            ki = KW'($urandom);
            kd = KW'($urandom);
            for (int i = 0; i < N; i++)
                errv[i] = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 64)) - 15'sd32;
            m0   = N'($urandom_range(1, 15));
            keep = ($urandom_range(0, 3) == 0) ? (m0 & N'($urandom)) : '0;
            late = (keep == '0) ? (N'($urandom) & ~m0) : '0;
            batch(m0, late, keep, $urandom_range(1, 8), keep == '0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pid_scheduler.md
# pid_scheduler

Time-multiplexed incremental PID controller serving N_CH control loops with one shared multiplier and one output accumulator. Round-robin arbitration picks a requesting channel, and a fixed FSM sequences the three coefficient products. The result is accumulated into that channel's stored output u(k) and returned with a one-cycle acknowledge. The block sits between the per-loop error sources and the actuator drivers, and replaces one increment/accumulate datapath per loop.

## Interface
- N_CH, 4: number of channels (2..16)
- W, 15: signed width of error, increment and output
- KW, 8: signed coefficient width
- SHIFT, 0: arithmetic right shift applied to the summed products
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- req  in  N_CH  level request per channel; held until that channel's ack
- err  in  N_CH*W  signed e(k) per channel, channel i at bits [i*W +: W]
- kp, ki, kd  in  KW each  signed coefficients shared by all channels
- ack  out  N_CH  one-hot, one-cycle pulse to the served channel
- uk_valid  out  1  high with ack
- uk_ch  out  clog2(N_CH)  index of the served channel
- uk  out  W  signed new u(k) of the served channel
- busy  out  1  high in every state except IDLE

## Operation
- Per-channel state registers: e1 (e(k-1)), e2 (e(k-2)), u (u(k-1)). All are W-bit signed.
- Reset clears every output, all e1/e2/u registers and the round-robin pointer to 0, and forces the FSM to IDLE. A reset during any state aborts the calculation with no ack and no state update.
- FSM states and transitions:
  - IDLE: if any req is set, grant the first requesting channel at or after the pointer, wrapping modulo N_CH, then go to LOAD. Otherwise stay in IDLE.
  - LOAD: latch err[g], kp, ki, kd. Form dP = e - e1, dI = e, dD = e - 2*e1 + e2, each W+2 bits signed.
  - MUL_P, MUL_I, MUL_D: one product per cycle through the shared multiplier, added into a (W+KW+4)-bit accumulator.
  - ACC: du = acc >>> SHIFT, limited to W bits. Then u_new = u[g] + du, limited to W bits. Write u[g] = u_new, e2[g] = e1[g], e1[g] = e. Set the pointer to g+1 (wrapping).
  - DONE: assert ack[g], uk_valid, uk_ch = g and uk = u_new for one cycle, then go to IDLE.
- Requests raised or dropped while busy are sampled only in IDLE. No request is lost provided it is held.
- A channel that keeps req high after its ack is served again only after every other pending channel has been served.
- Changes to err or the coefficients after LOAD do not affect the calculation in progress.

## Timing
- A req seen in IDLE at cycle t gives LOAD at t+1, MUL_P at t+2, MUL_I at t+3, MUL_D at t+4, ACC at t+5, and DONE at t+6 with ack high.
- Throughput is one update per 7 cycles.
- All outputs are registered. Between DONE pulses uk, uk_ch and uk_valid read 0.

## Configuration
- PID_SAT_EN defined:
  - du and u_new clamp to [-2^(W-1), 2^(W-1)-1].
  - The product accumulator is wide enough never to overflow.
- PID_SAT_EN undefined:
  - du and u_new are truncated to W bits, so values wrap two's-complement.
  - This matches the legacy unsaturated accumulator.

## Structure
- Package pid_pkg holds:
  - the FSM state enum (IDLE, LOAD, MUL_P, MUL_I, MUL_D, ACC, DONE);
  - the default W and KW localparams;
  - the saturate function used under PID_SAT_EN.
- One sub-module, pid_rr_arb: the N_CH round-robin arbiter. Its inputs are req and the pointer; its outputs are the granted index and a valid flag. It is purely combinational and is registered by the FSM.

## Test plan
All scenarios use N_CH=4, W=15, KW=8, SHIFT=0.
- First update: after reset, kp=2, ki=1, kd=0, err0=10, req=0001. Required: ack=0001 exactly 6 cycles after req is seen, uk=30, uk_ch=0.
- Repeat update: hold err0=10 and request again. Required: uk=40. With kd=1 set for this request instead, uk=30 (30 + 0 + 10 - 10).
- Round-robin: req=1111 held for 5 updates. Required: ack order is channels 0, 1, 2, 3, 0, with DONE pulses 7 cycles apart.
- Saturation: preload ch1 to u=16380, then kp=0, ki=1, err1=30. Required: uk=16383 with PID_SAT_EN, and uk=-16358 without it.
- Reset mid-operation: assert rst in MUL_I for ch2. Required: no ack, busy=0 on the next cycle, and the next ch2 request computes from e1=e2=u=0.
- Late request: raise req3 while ch0 is in MUL_P. Required: ch0 completes unaffected and ch3 is acked 7 cycles after ch0's DONE.
